// File: rtl/credit_rd_arbiter.sv
// credit_rd_arbiter: two AXI-Stream address requesters share one RAM read port.
// Each read is issued only when the requester's output FIFO has a reserved slot,
// so the per-channel first-word-fall-through FIFOs never overflow.
module credit_rd_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  s0_tdata,
  input  logic        s0_tvalid,
  output logic        s0_tready,
  input  logic [7:0]  s1_tdata,
  input  logic        s1_tvalid,
  output logic        s1_tready,
  output logic        ram_rd_en,
  output logic [7:0]  ram_rd_addr,
  input  logic [15:0] ram_rd_data,
  output logic [15:0] m0_tdata,
  output logic        m0_tvalid,
  input  logic        m0_tready,
  output logic [15:0] m1_tdata,
  output logic        m1_tvalid,
  input  logic        m1_tready,
  output logic        overflow,
  output logic        busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CRED_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic {RR_CH0, RR_CH1} rr_t;

  rr_t             rr_ptr;
  logic            active;
  logic [1:0]      s_tvalid;
  logic [1:0]      m_tready;
  logic [1:0]      elig;
  logic [1:0]      grant;
  logic [1:0]      pop;
  logic [1:0]      m_tvalid;
  logic [1:0]      ovf_hit;
  logic [15:0]     m_tdata [2];
  logic [RD_LATENCY:0] tag_vld;
  logic [RD_LATENCY:0] tag_ch;

  assign s_tvalid  = {s1_tvalid, s0_tvalid};
  assign m_tready  = {m1_tready, m0_tready};
  assign s0_tready = grant[0];
  assign s1_tready = grant[1];
  assign m0_tvalid = m_tvalid[0];
  assign m1_tvalid = m_tvalid[1];
  assign m0_tdata  = m_tdata[0];
  assign m1_tdata  = m_tdata[1];
  assign ram_rd_en = tag_vld[0];
  assign busy      = (|tag_vld) | (|m_tvalid) | ram_rd_en;

  // Single grant per cycle: lone eligible channel wins, a tie goes to the RR pointer
  always_comb begin
    grant = '0;
    if (elig[0] && (!elig[1] || rr_ptr == RR_CH0)) begin
      grant[0] = 1'b1;
    end else if (elig[1]) begin
      grant[1] = 1'b1;
    end
  end

  // Enable flop gives a synchronous release: no grant can be issued while in reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
    end else begin
      active <= 1'b1;
    end
  end

  // Issue stage: register the RAM address, launch the channel tag, advance RR on ties
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= RR_CH0;
      ram_rd_addr <= '0;
      tag_vld     <= '0;
      tag_ch      <= '0;
    end else begin
      if (elig[0] && elig[1]) begin
        rr_ptr <= grant[0] ? RR_CH1 : RR_CH0;
      end
      if (grant[1]) begin
        ram_rd_addr <= s1_tdata;
      end else if (grant[0]) begin
        ram_rd_addr <= s0_tdata;
      end
      tag_vld <= {tag_vld[RD_LATENCY-1:0], |grant};
      tag_ch  <= {tag_ch[RD_LATENCY-1:0], grant[1]};
    end
  end

  // Sticky flag: any write that found its FIFO full
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (|ovf_hit) begin
      overflow <= 1'b1;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_ch
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] credit;
    logic          empty;
    logic          full;
    logic          wr_req;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_req      = tag_vld[RD_LATENCY] && (tag_ch[RD_LATENCY] == 1'(k));
    assign m_tvalid[k] = !empty;
    assign m_tdata[k]  = mem[rd_ptr[AW-1:0]];
    assign pop[k]      = !empty && m_tready[k];
    assign ovf_hit[k]  = wr_req && full;
    assign elig[k]     = active && s_tvalid[k] && (credit != '0);

    // FWFT FIFO: returning RAM word enters at the write pointer, head pops on handshake
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        mem    <= '{default: '0};
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_req && !full) begin
          mem[wr_ptr[AW-1:0]] <= ram_rd_data;
          wr_ptr              <= wr_ptr + PTR_ONE;
        end
        if (pop[k]) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
    end

    // Credit: one slot reserved per accepted address, returned when the word is popped
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        credit <= CW'(FIFO_DEPTH);
      end else begin
        case ({grant[k], pop[k]})
          2'b10:   credit <= credit - CRED_ONE;
          2'b01:   credit <= credit + CRED_ONE;
          default: credit <= credit;
        endcase
      end
    end
  end

endmodule
